ras_ctrl: RTL

//  Sequencer for the return address stack (RAS). Sits between fetch predecode and the RAS.
//  - Turns call/ret/coroutine hints into RAS push/pop commands and supplies the predicted return target.
//  - Keeps a per-branch-tag snapshot of stack pointer and top entry, and drives RAS recovery on a CDB mispredict.

---
 rtl/ras_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ras_ctrl.sv
// ras_ctrl: return address stack sequencer.
// Turns call/ret hints from fetch predecode into RAS push/pop strobes and predicts
// return targets. It also keeps one snapshot of stack pointer and top entry per
// in-flight branch tag, and drives RAS recovery when the CDB reports a mispredict.
// A RAS entry is {valid, addr[31:0]}.
module ras_ctrl #(
   parameter  int RAS_DEPTH = 32,
   parameter  int NUM_BR    = 8,
   localparam int PTR_W     = $clog2(RAS_DEPTH),
   localparam int TAG_W     = $clog2(NUM_BR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fe_valid,
   input  logic             fe_is_call,
   input  logic             fe_is_ret,
   input  logic [31:0]      fe_ret_addr,
   output logic             fe_stall,
   output logic             pred_valid,
   output logic [31:0]      pred_target,
   output logic             ras_push,
   output logic             ras_pop,
   output logic [32:0]      ras_din,
   input  logic [32:0]      ras_dout,
   input  logic [PTR_W-1:0] ras_sp,
   input  logic             br_alloc,
   input  logic [TAG_W-1:0] br_tag,
   input  logic             cdb_broadcast,
   input  logic             cdb_br_mispred,
   input  logic [TAG_W-1:0] cdb_br_tag,
   output logic [32:0]      br_ras_top,
   output logic [PTR_W-1:0] br_stack_ptr_val
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORO = 2'd1,
      RPOP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [PTR_W-1:0] snap_sp  [NUM_BR];
   logic [32:0]      snap_top [NUM_BR];
   logic             snap_ret [NUM_BR];

   logic mispred;
   logic dout_valid;
   logic snap_we;

   assign mispred    = cdb_broadcast & cdb_br_mispred;
   assign dout_valid = ras_dout[32];
   assign snap_we    = br_alloc & fe_valid & (state == IDLE) & ~mispred;

   // Next-state selection; a mispredict overrides any pending coroutine push or replay pop.
   always_comb begin
      state_nxt = IDLE;
      if (mispred) begin
         state_nxt = snap_ret[cdb_br_tag] ? RPOP : IDLE;
      end else if (state == IDLE && fe_valid && fe_is_call && fe_is_ret) begin
         state_nxt = CORO;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Per-tag snapshot of sp/top taken when a branch is allocated.
   // A call records the post-push view so recovery lands as if the call had retired.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_BR; i++) begin
            snap_sp[i]  <= '0;
            snap_top[i] <= '0;
            snap_ret[i] <= 1'b0;
         end
      end else if (snap_we) begin
         if (fe_is_call) begin
            snap_sp[br_tag]  <= ras_sp + PTR_W'(1);
            snap_top[br_tag] <= {1'b1, fe_ret_addr};
            snap_ret[br_tag] <= 1'b0;
         end else if (fe_is_ret) begin
            snap_sp[br_tag]  <= ras_sp;
            snap_top[br_tag] <= ras_dout;
            snap_ret[br_tag] <= dout_valid;
         end else begin
            snap_sp[br_tag]  <= ras_sp;
            snap_top[br_tag] <= ras_dout;
            snap_ret[br_tag] <= 1'b0;
         end
      end
   end

   // Push/pop/stall decode; all strobes forced low while in reset.
   always_comb begin
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      fe_stall = 1'b0;
      if (!rst) begin
         if (mispred) begin
            fe_stall = 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (fe_valid) begin
                     if (fe_is_call && fe_is_ret) begin
                        ras_pop  = dout_valid;
                        fe_stall = 1'b1;
                     end else if (fe_is_call) begin
                        ras_push = 1'b1;
                     end else if (fe_is_ret) begin
                        ras_pop = dout_valid;
                     end
                  end
               end
               CORO: begin
                  ras_push = 1'b1;
               end
               RPOP: begin
                  ras_pop  = 1'b1;
                  fe_stall = 1'b1;
               end
               default: begin
                  ras_push = 1'b0;
               end
            endcase
         end
      end
   end

   // Prediction, push data and snapshot readout; zero during reset.
   always_comb begin
      pred_valid       = 1'b0;
      pred_target      = '0;
      ras_din          = '0;
      br_ras_top       = '0;
      br_stack_ptr_val = '0;
      if (!rst) begin
         pred_valid       = fe_valid & fe_is_ret & dout_valid & (state == IDLE);
         pred_target      = ras_dout[31:0];
         ras_din          = {1'b1, fe_ret_addr};
         br_ras_top       = snap_top[cdb_br_tag];
         br_stack_ptr_val = snap_sp[cdb_br_tag];
      end
   end

endmodule
